mem_port_arbiter: RTL and testbench

Arbitrates the core's single unified memory port between the instruction-fetch stage (IF) and the load/store MEM stage (DM). Only one transaction is outstanding at a time. The block tracks the owner of that transaction and routes the response back to it. DM has priority, with a starvation guard for IF. A fetch-flush input discards stale instruction responses after a branch or jump redirect.

---
 rtl/mem_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one unified memory port between instruction fetch (IF) and the
//   load/store stage (DM). Only one transaction is in flight at a time; its
//   owner is recorded so the response goes back to the right requester.
//   DM wins contention unless IF has lost STARVE_MAX times in a row.
//   if_flush discards the response of an in-flight fetch.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   if_req/if_addr                  fetch request (held until if_gnt)
//   if_flush                        drop the outstanding fetch response
//   if_gnt, if_rvalid, if_rdata     fetch grant pulse, response pulse, data
//   dm_req/dm_we/dm_addr/dm_wdata   load/store request (held until dm_gnt)
//   dm_gnt, dm_rvalid, dm_rdata     data grant pulse, response pulse, data
//   mem_req/mem_we/mem_addr/
//   mem_wdata                       memory request, held until mem_ready
//   mem_ready                       memory accepts the request this cycle
//   mem_rvalid/mem_rdata            memory read response
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    RESP
  } state_e;

  state_e            state_q;
  logic [SW-1:0]     streak_q;
  logic              owner_if_q;
  logic              drop_q;
  logic              drop_d;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic              dm_rvalid_q;
  logic [DATA_W-1:0] dm_rdata_q;

  logic idle;
  logic if_wins;
  logic if_gnt_w;
  logic dm_gnt_w;

  assign idle    = (state_q == IDLE);
  assign if_wins = if_req & (~dm_req | (streak_q == STREAK_MAX));
  // rst_n gating keeps the combinational grants at 0 while reset is held.
  assign if_gnt_w = rst_n & idle & if_wins;
  assign dm_gnt_w = rst_n & idle & dm_req & ~if_wins;

  // A flush in the grant cycle already belongs to the new fetch.
  assign drop_d = drop_q | (if_flush & ((~idle & owner_if_q) | if_gnt_w));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      owner_if_q  <= 1'b0;
      drop_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rvalid_q <= 1'b0;
      dm_rdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (if_gnt_w || dm_gnt_w) begin
            state_q     <= ISSUE;
            owner_if_q  <= if_gnt_w;
            drop_q      <= drop_d;
            mem_req_q   <= 1'b1;
            mem_we_q    <= dm_gnt_w & dm_we;
            mem_addr_q  <= if_gnt_w ? if_addr : dm_addr;
            mem_wdata_q <= if_gnt_w ? '0 : dm_wdata;
            if (if_gnt_w) begin
              streak_q <= '0;
            end else if (if_req) begin
              streak_q <= (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
            end else begin
              streak_q <= '0;
            end
          end
        end
        ISSUE: begin
          drop_q <= drop_d;
          if (mem_ready) begin
            mem_req_q <= 1'b0;
            if (mem_we_q) begin
              state_q     <= RESP;
              dm_rvalid_q <= 1'b1;
              dm_rdata_q  <= '0;
            end else begin
              state_q <= WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          drop_q <= drop_d;
          if (mem_rvalid) begin
            state_q <= RESP;
            if (owner_if_q) begin
              // drop_d so a flush arriving with the data still suppresses it
              if (!drop_d) begin
                if_rvalid_q <= 1'b1;
                if_rdata_q  <= mem_rdata;
              end
            end else begin
              dm_rvalid_q <= 1'b1;
              dm_rdata_q  <= mem_rdata;
            end
          end
        end
        RESP: begin
          state_q     <= IDLE;
          if_rvalid_q <= 1'b0;
          dm_rvalid_q <= 1'b0;
          drop_q      <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_gnt    = if_gnt_w;
  assign dm_gnt    = dm_gnt_w;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rvalid = dm_rvalid_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_flush, if_gnt, if_rvalid;
  logic [63:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [63:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          owner_if;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] data;
    bit          drop;
    int          gcyc;
    int          stall;
    int          rdly;
  } txn_t;

  txn_t sb[$];
  logic [63:0] ref_mem [logic [63:0]];
  logic [63:0] mem     [logic [63:0]];

  int checks = 0;
  int errors = 0;

  // configuration written by the main sequence
  bit cfg_rand = 0;
  int cfg_stall = 0;
  int cfg_rdly = 0;
  bit order_phase = 0;
  bit inject_ghost = 0;

  // written only by the monitor
  bit m_busy = 0;
  int m_streak = 0;
  int n_if_gnt = 0;
  int n_dm_gnt = 0;
  bit order_done = 0;
  int busy_cnt = 0;
  bit glog[$];

  // written only by the responder
  int resp_at = -1;

  function automatic logic [63:0] dflt(input logic [63:0] a);
    if (a == 64'h1000) return 64'h0000_0000_00A0_0093;
    return {~a[31:0], a[31:0] ^ 32'h5A5A_0F0F};
  endfunction

  // Memory model: stalls mem_ready per transaction, then returns read data.
  int rs = 0;
  int rcnt = 0;
  logic [63:0] la, lwd;
  bit lwe;
  initial begin
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
      if (!rst_n) begin
        rs = 0; resp_at = -1;
      end else begin
        if (inject_ghost && rs == 0) begin
          mem_rvalid = 1; mem_rdata = '1;
        end
        if (rs == 0 && mem_req && sb.size() > 0) begin
          la = mem_addr; lwe = mem_we; lwd = mem_wdata; rcnt = sb[0].stall; rs = 1;
        end
        if (rs == 1) begin
          if (rcnt == 0) begin
            mem_ready = 1;
            if (lwe) begin
              mem[la] = lwd; resp_at = cyc + 1; rs = 0;
            end else begin
              rcnt = sb[0].rdly; rs = 2;
            end
          end else rcnt--;
        end else if (rs == 2) begin
          if (rcnt == 0) begin
            mem_rvalid = 1;
            mem_rdata = mem.exists(la) ? mem[la] : dflt(la);
            resp_at = cyc + 1; rs = 0;
          end else rcnt--;
        end
      end
    end
  end

  // Monitor / scoreboard.
  bit exp_if, exp_dm;
  txn_t mt;
  logic [9:0] got_v, exp_v;
  int lat, exp_lat;
  always @(negedge clk) begin
    if (!rst_n) begin
      checks++;
      if ({if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_req, mem_we} !== 6'b0 ||
          if_rdata !== '0 || dm_rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got gnt=%b%b rv=%b%b mreq=%b mwe=%b maddr=%h, expected all zero",
                 if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, mem_we, mem_addr);
      end
      sb.delete(); m_busy = 0; m_streak = 0; busy_cnt = 0;
    end else begin
      exp_if = !m_busy && if_req && (!dm_req || m_streak == SMAX);
      exp_dm = !m_busy && dm_req && !exp_if;
      if (if_req || dm_req || if_gnt || dm_gnt) begin
        checks++;
        if (if_gnt !== exp_if || dm_gnt !== exp_dm) begin
          errors++;
          $display("FAIL grant @%0d: got if_gnt=%b dm_gnt=%b, expected %b %b", cyc, if_gnt, dm_gnt, exp_if, exp_dm);
        end
      end
      if (if_gnt === 1'b1) n_if_gnt++;
      if (dm_gnt === 1'b1) n_dm_gnt++;
      if (order_phase && !order_done && (if_gnt === 1'b1 || dm_gnt === 1'b1)) begin
        glog.push_back(if_gnt);
        if (glog.size() == 10) begin
          for (int i = 0; i < 10; i++) begin
            got_v[i] = glog[i];
            exp_v[i] = (i % 5 == 4);
          end
          checks++;
          if (got_v !== exp_v) begin
            errors++;
            $display("FAIL grant_order: got IF-grant mask %b, expected %b", got_v, exp_v);
          end
          order_done = 1;
        end
      end
      if (exp_if || exp_dm) begin
        mt.owner_if = exp_if;
        mt.we       = exp_dm && dm_we;
        mt.addr     = exp_if ? if_addr : dm_addr;
        mt.wdata    = dm_wdata;
        mt.drop     = 0;
        mt.gcyc     = cyc;
        mt.stall    = cfg_rand ? int'($urandom_range(0, 3)) : cfg_stall;
        mt.rdly     = cfg_rand ? int'($urandom_range(0, 3)) : cfg_rdly;
        if (mt.we) begin
          ref_mem[mt.addr] = mt.wdata;
          mt.data = '0;
        end else begin
          mt.data = ref_mem.exists(mt.addr) ? ref_mem[mt.addr] : dflt(mt.addr);
        end
        sb.push_back(mt);
        m_busy = 1;
        if (exp_if) m_streak = 0;
        else if (if_req) m_streak = (m_streak < SMAX) ? m_streak + 1 : SMAX;
        else m_streak = 0;
      end
      if (if_flush && sb.size() > 0 && cyc != resp_at) begin
        if (sb[0].owner_if) sb[0].drop = 1;
      end
      if (mem_req === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL mem_req_spurious @%0d: got mem_req=1 addr=%h, expected no request", cyc, mem_addr);
        end else if (mem_addr !== sb[0].addr || mem_we !== sb[0].we ||
                     (sb[0].we && mem_wdata !== sb[0].wdata)) begin
          errors++;
          $display("FAIL mem_fields @%0d: got we=%b addr=%h wdata=%h, expected we=%b addr=%h wdata=%h",
                   cyc, mem_we, mem_addr, mem_wdata, sb[0].we, sb[0].addr, sb[0].wdata);
        end
      end
      if (cyc == resp_at) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp_no_txn @%0d: got a memory completion, expected none outstanding", cyc);
        end else begin
          mt = sb.pop_front();
          checks++;
          if (if_rvalid !== (mt.owner_if && !mt.drop) || dm_rvalid !== !mt.owner_if) begin
            errors++;
            $display("FAIL resp_valid @%0d: got if_rvalid=%b dm_rvalid=%b, expected %b %b",
                     cyc, if_rvalid, dm_rvalid, mt.owner_if && !mt.drop, !mt.owner_if);
          end
          if (mt.owner_if && !mt.drop) begin
            checks++;
            if (if_rdata !== mt.data) begin
              errors++;
              $display("FAIL if_rdata @%0d: got %h, expected %h", cyc, if_rdata, mt.data);
            end
          end
          if (!mt.owner_if) begin
            checks++;
            if (dm_rdata !== mt.data) begin
              errors++;
              $display("FAIL dm_rdata @%0d: got %h, expected %h", cyc, dm_rdata, mt.data);
            end
          end
          lat = cyc - mt.gcyc;
          exp_lat = mt.we ? 2 + mt.stall : 3 + mt.stall + mt.rdly;
          checks++;
          if (lat != exp_lat) begin
            errors++;
            $display("FAIL latency @%0d: got %0d cycles, expected %0d", cyc, lat, exp_lat);
          end
          m_busy = 0;
        end
      end else if (if_rvalid === 1'b1 || dm_rvalid === 1'b1) begin
        checks++; errors++;
        $display("FAIL unexpected_rvalid @%0d: got if_rvalid=%b dm_rvalid=%b, expected 0 0", cyc, if_rvalid, dm_rvalid);
      end
      busy_cnt = m_busy ? busy_cnt + 1 : 0;
      if (busy_cnt == 60) begin
        checks++; errors++;
        $display("FAIL watchdog @%0d: got transaction still open after 60 cycles, expected completion", cyc);
        sb.delete(); m_busy = 0; busy_cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_if(input logic [63:0] a);
    int base;
    base = n_if_gnt;
    if_req = 1; if_addr = a;
    for (int k = 0; k < 50 && n_if_gnt == base; k++) step();
    if_req = 0;
  endtask

  task automatic do_dm(input bit we, input logic [63:0] a, input logic [63:0] wd);
    int base;
    base = n_dm_gnt;
    dm_req = 1; dm_we = we; dm_addr = a; dm_wdata = wd;
    for (int k = 0; k < 50 && n_dm_gnt == base; k++) step();
    dm_req = 0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 150 && m_busy; k++) step();
  endtask

  int ib, db;
  initial begin
    rst_n = 0; if_req = 0; if_addr = '0; if_flush = 0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    repeat (3) step();
    rst_n = 1;
    step();

    // single fetch
    do_if(64'h1000); wait_idle();

    // store then load of the same address
    do_dm(1, 64'h2000, 64'h0000_0000_DEAD_BEEF); wait_idle();
    do_dm(0, 64'h2000, '0); wait_idle();

    // priority / starvation with both requests held
    order_phase = 1;
    if_addr = 64'h40; dm_we = 0; dm_addr = 64'h48;
    if_req = 1; dm_req = 1;
    for (int k = 0; k < 120 && !order_done; k++) step();
    if_req = 0; dm_req = 0; order_phase = 0;
    wait_idle();

    // flush during WAIT_RSP, then a normal request
    cfg_rdly = 2;
    do_if(64'h80);
    step(); if_flush = 1;
    step(); if_flush = 0;
    wait_idle();
    cfg_rdly = 0;
    do_if(64'h80); wait_idle();

    // backpressure
    cfg_stall = 3; cfg_rdly = 2;
    do_dm(0, 64'h88, '0); wait_idle();
    do_dm(1, 64'h88, 64'h1234_5678_9ABC_DEF0); wait_idle();
    cfg_stall = 0; cfg_rdly = 0;

    // reset in WAIT_RSP, then a late mem_rvalid
    cfg_rdly = 5;
    do_dm(0, 64'h90, '0);
    step(); rst_n = 0;
    step(); step(); rst_n = 1;
    step(); inject_ghost = 1;
    step(); inject_ghost = 0;
    cfg_rdly = 0;
    do_dm(0, 64'h90, '0); wait_idle();

    // randomized traffic
    cfg_rand = 1;
    ib = 0; db = 0;
    repeat (2500) begin
      step();
      if (if_req && n_if_gnt != ib) if_req = 0;
      if (dm_req && n_dm_gnt != db) dm_req = 0;
      if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1; if_addr = 64'($urandom_range(0, 15) * 8); ib = n_if_gnt;
      end
      if (!dm_req && $urandom_range(0, 3) == 0) begin
        dm_req = 1; dm_we = 1'($urandom_range(0, 1));
        dm_addr = 64'($urandom_range(0, 15) * 8);
        dm_wdata = {$urandom, $urandom}; db = n_dm_gnt;
      end
      if_flush = ($urandom_range(0, 7) == 0);
    end
    if_req = 0; dm_req = 0; if_flush = 0;
    wait_idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
